// File: rtl/fpga_permute_ctrl.sv
// fpga_permute_ctrl: Moore sequencing FSM for the FPGA permutation datapath.
// Walks the 5x5 cell memory one cell per iteration (read, write back,
// next-i computation, update) until the datapath flags done.
// Optional build macro: FCTRL_ADJ_LIMIT_EN bounds consecutive ADJ cycles
// to ADJ_MAX and traps in ERR on overrun; without it ERR is unreachable.
module fpga_permute_ctrl #(
    parameter int unsigned ADJ_MAX = 4,
    parameter int unsigned ITER_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic              sign,
    output logic              IJen,
    output logic              IJregen,
    output logic              initLine,
    output logic              firstread,
    output logic              read,
    output logic              write,
    output logic              writeVal,
    output logic              writeMemReg,
    output logic              ldTillPositive,
    output logic              waitCalNexti,
    output logic              update,
    output logic              ok,
    output logic              ready,
    output logic              busy,
    output logic [ITER_W-1:0] iter,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_CALC,
        S_ADJ,
        S_UPDATE,
        S_CHECK,
        S_FIN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   iter_q;

`ifdef FCTRL_ADJ_LIMIT_EN
    localparam logic [2:0] ADJ_LAST = 3'(ADJ_MAX - 1);

    logic [2:0] adj_cnt_q;

    // ADJ run-length counter: cleared while in CALC (the only way into ADJ)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adj_cnt_q <= '0;
        end else if (state_q == S_CALC) begin
            adj_cnt_q <= '0;
        end else if (state_q == S_ADJ) begin
            adj_cnt_q <= adj_cnt_q + 3'd1;
        end
    end
`else
    logic unused_adj_max;
    assign unused_adj_max = (ADJ_MAX == 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completed-iteration counter: cleared on accepted start, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            iter_q <= '0;
        end else if (state_q == S_UPDATE && iter_q != '1) begin
            iter_q <= iter_q + ITER_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_INIT;
            S_INIT:   state_d = S_LOAD;
            S_LOAD:   state_d = S_READ;
            S_READ:   state_d = S_WRITE;
            S_WRITE:  state_d = S_CALC;
            S_CALC:   state_d = S_ADJ;
            S_ADJ: begin
                if (!sign) begin
                    state_d = S_UPDATE;
`ifdef FCTRL_ADJ_LIMIT_EN
                end else if (adj_cnt_q == ADJ_LAST) begin
                    state_d = S_ERR;
`endif
                end
            end
            S_UPDATE: state_d = S_CHECK;
            S_CHECK:  state_d = done ? S_FIN : S_READ;
            S_FIN:    state_d = S_IDLE;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode: every control depends on state only
    always_comb begin
        IJen           = 1'b0;
        IJregen        = 1'b0;
        initLine       = 1'b0;
        firstread      = 1'b0;
        read           = 1'b0;
        write          = 1'b0;
        writeVal       = 1'b0;
        writeMemReg    = 1'b0;
        ldTillPositive = 1'b0;
        waitCalNexti   = 1'b0;
        update         = 1'b0;
        ok             = 1'b0;
        ready          = 1'b0;
        busy           = 1'b1;
        err            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            S_INIT: begin
                initLine  = 1'b1;
                firstread = 1'b1;
                IJen      = 1'b1;
            end
            S_LOAD: begin
                IJen    = 1'b1;
                IJregen = 1'b1;
            end
            S_READ: begin
                read        = 1'b1;
                writeVal    = 1'b1;
                writeMemReg = 1'b1;
            end
            S_WRITE:  write = 1'b1;
            S_CALC:   ldTillPositive = 1'b1;
            S_ADJ: begin
                ldTillPositive = 1'b1;
                waitCalNexti   = 1'b1;
            end
            S_UPDATE: begin
                update  = 1'b1;
                IJregen = 1'b1;
            end
            S_CHECK:  ;
            S_FIN:    ok = 1'b1;
            S_ERR: begin
                busy = 1'b0;
`ifdef FCTRL_ADJ_LIMIT_EN
                err  = 1'b1;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_fpga_permute_ctrl.sv
// tb_fpga_permute_ctrl: directed self-checking bench for fpga_permute_ctrl.
// All outputs are packed into one vector and compared against per-state
// constants derived by hand from the state/output table.
module tb_fpga_permute_ctrl;

    localparam int unsigned ITER_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              done = 1'b0;
    logic              sign = 1'b0;
    logic              IJen, IJregen, initLine, firstread, read, write;
    logic              writeVal, writeMemReg, ldTillPositive, waitCalNexti;
    logic              update, ok, ready, busy, err;
    logic [ITER_W-1:0] iter;

    int checks = 0;
    int errors = 0;

    fpga_permute_ctrl #(.ADJ_MAX(4), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .sign(sign),
        .IJen(IJen), .IJregen(IJregen), .initLine(initLine),
        .firstread(firstread), .read(read), .write(write),
        .writeVal(writeVal), .writeMemReg(writeMemReg),
        .ldTillPositive(ldTillPositive), .waitCalNexti(waitCalNexti),
        .update(update), .ok(ok), .ready(ready), .busy(busy),
        .iter(iter), .err(err)
    );

    always #5 clk = ~clk;

    // [14]IJen [13]IJregen [12]initLine [11]firstread [10]read [9]write
    // [8]writeVal [7]writeMemReg [6]ldTillPositive [5]waitCalNexti
    // [4]update [3]ok [2]ready [1]busy [0]err
    logic [14:0] ctl;
    assign ctl = {IJen, IJregen, initLine, firstread, read, write, writeVal,
                  writeMemReg, ldTillPositive, waitCalNexti, update, ok,
                  ready, busy, err};

    localparam logic [14:0] C_IDLE   = 15'b000000000000100;
    localparam logic [14:0] C_INIT   = 15'b101100000000010;
    localparam logic [14:0] C_LOAD   = 15'b110000000000010;
    localparam logic [14:0] C_READ   = 15'b000010110000010;
    localparam logic [14:0] C_WRITE  = 15'b000001000000010;
    localparam logic [14:0] C_CALC   = 15'b000000001000010;
    localparam logic [14:0] C_ADJ    = 15'b000000001100010;
    localparam logic [14:0] C_UPDATE = 15'b010000000010010;
    localparam logic [14:0] C_CHECK  = 15'b000000000000010;
    localparam logic [14:0] C_FIN    = 15'b000000000001010;
    localparam logic [14:0] C_ERR    = 15'b000000000000001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ctl !== C_IDLE) begin
                errors++;
                $display("FAIL reset_ctl cyc%0d got %b want %b", c, ctl, C_IDLE);
            end
            checks++;
            if (iter !== '0) begin
                errors++;
                $display("FAIL reset_iter cyc%0d got %0d want 0", c, iter);
            end
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_release got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_minimal_pass();
        logic [14:0] exp_seq [10];
        exp_seq = '{C_INIT, C_LOAD, C_READ, C_WRITE, C_CALC, C_ADJ,
                    C_UPDATE, C_CHECK, C_FIN, C_IDLE};
        sign = 1'b0;
        done = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (ctl !== exp_seq[c-1]) begin
                errors++;
                $display("FAIL min_pass_ctl cyc%0d got %b want %b", c, ctl, exp_seq[c-1]);
            end
            if (c >= 8) begin
                checks++;
                if (iter !== 5'd1) begin
                    errors++;
                    $display("FAIL min_pass_iter cyc%0d got %0d want 1", c, iter);
                end
            end
        end
        // back-to-back start straight from IDLE clears iter
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ctl !== C_INIT) begin
            errors++;
            $display("FAIL b2b_init got %b want %b", ctl, C_INIT);
        end
        checks++;
        if (iter !== 5'd0) begin
            errors++;
            $display("FAIL b2b_iter_clear got %0d want 0", iter);
        end
        for (int c = 0; c < 9; c++) tick();
        checks++;
        if (ctl !== C_IDLE || iter !== 5'd1) begin
            errors++;
            $display("FAIL b2b_end got %b iter %0d want %b iter 1", ctl, iter, C_IDLE);
        end
    endtask

    task automatic test_adj_loop();
        logic [14:0] exp_seq [12];
        exp_seq = '{C_INIT, C_LOAD, C_READ, C_WRITE, C_CALC, C_ADJ, C_ADJ,
                    C_ADJ, C_UPDATE, C_CHECK, C_FIN, C_IDLE};
        done = 1'b1;
        sign = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (ctl !== exp_seq[c-1]) begin
                errors++;
                $display("FAIL adj_loop_ctl cyc%0d got %b want %b", c, ctl, exp_seq[c-1]);
            end
            // sign=1 for the first two ADJ cycles (6,7), 0 in the third (8)
            sign = (c != 8);
        end
        sign = 1'b0;
    endtask

    task automatic run_multi(input int nzero, input int exp_iter);
        int last_check;
        int fin;
        int r;
        int k;
        int exp_i;
        logic [14:0] e;
        last_check = 8 + 6 * nzero;
        fin = last_check + 1;
        done = 1'b0;
        sign = 1'b0;
        start = 1'b1;   // held high throughout: must be ignored while busy and in FIN
        for (int c = 1; c <= fin + 1; c++) begin
            tick();
            if (c == 1)               e = C_INIT;
            else if (c == 2)          e = C_LOAD;
            else if (c <= last_check) begin
                r = (c - 3) % 6;
                case (r)
                    0: e = C_READ;
                    1: e = C_WRITE;
                    2: e = C_CALC;
                    3: e = C_ADJ;
                    4: e = C_UPDATE;
                    default: e = C_CHECK;
                endcase
            end
            else if (c == fin)        e = C_FIN;
            else                      e = C_IDLE;
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL multi%0d_ctl cyc%0d got %b want %b", nzero, c, ctl, e);
            end
            if (c > 2 && c <= last_check && (c - 3) % 6 == 5) begin
                k = (c - 3) / 6;
                exp_i = (k + 1 > 31) ? 31 : k + 1;
                checks++;
                if (iter !== exp_i[ITER_W-1:0]) begin
                    errors++;
                    $display("FAIL multi%0d_iter cyc%0d got %0d want %0d", nzero, c, iter, exp_i);
                end
            end
            if (c == fin) begin
                checks++;
                if (iter !== exp_iter[ITER_W-1:0]) begin
                    errors++;
                    $display("FAIL multi%0d_final_iter got %0d want %0d", nzero, iter, exp_iter);
                end
            end
            done = (c == last_check);
        end
        start = 1'b0;
        done = 1'b0;
    endtask

    task automatic test_multi_iter();
        run_multi(23, 24);
    endtask

    task automatic test_iter_saturate();
        run_multi(34, 31);
    endtask

    task automatic test_reset_mid_pass();
        done = 1'b0;
        sign = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (ctl !== C_WRITE || iter !== 5'd1) begin
            errors++;
            $display("FAIL midrst_pre got %b iter %0d want %b iter 1", ctl, iter, C_WRITE);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL midrst_write got %b want 0", write);
        end
        checks++;
        if (ctl !== C_IDLE || iter !== 5'd0) begin
            errors++;
            $display("FAIL midrst_state got %b iter %0d want %b iter 0", ctl, iter, C_IDLE);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL midrst_after got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_adj_limit();
        logic [14:0] e;
        done = 1'b0;
        sign = 1'b1;
        start = 1'b1;
`ifdef FCTRL_ADJ_LIMIT_EN
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            if (c == 5)      e = C_CALC;
            else if (c < 10) e = (c >= 6) ? C_ADJ : 15'b0;
            else             e = C_ERR;
            if (c >= 5) begin
                checks++;
                if (ctl !== e) begin
                    errors++;
                    $display("FAIL adj_limit_ctl cyc%0d got %b want %b", c, ctl, e);
                end
            end
            if (c == 11) sign = 1'b0;
        end
`else
        for (int c = 1; c <= 26; c++) begin
            tick();
            start = 1'b0;
            if (c == 5)      e = C_CALC;
            else if (c < 26) e = C_ADJ;
            else             e = C_UPDATE;
            if (c >= 5) begin
                checks++;
                if (ctl !== e) begin
                    errors++;
                    $display("FAIL adj_nolimit_ctl cyc%0d got %b want %b", c, ctl, e);
                end
            end
            if (c == 25) sign = 1'b0;
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL adj_limit_rst got %b want %b", ctl, C_IDLE);
        end
        tick();
        rst = 1'b1;
        sign = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_minimal_pass();
        test_adj_loop();
        test_multi_iter();
        test_iter_saturate();
        test_reset_mid_pass();
        test_adj_limit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
